// File: rtl/exe_stage.sv
// exe_stage: execute stage that forms Val2, runs the ALU, computes the branch target and holds NZCV.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        MEM_WB_EN,
  input  logic        B,
  input  logic        S,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        Imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest,
  input  logic        Carry,
  output logic [31:0] ALU_Res,
  output logic [31:0] Br_Addr,
  output logic        Branch_taken,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        MEM_WB_EN_out,
  output logic [3:0]  Status
);
  logic [4:0]  shiftAmt;
  logic [31:0] rotImm, shifted, val2, opB;
  logic [32:0] sum;
  logic        isArith, isSub, cin, nextC, nextV;
  always_comb begin
    shiftAmt = Shift_operand[11:7];
    rotImm   = 32'({2{24'b0, Shift_operand[7:0]}} >> {Shift_operand[11:8], 1'b0});
    shifted  = Shift_operand[6:5] == 2'b00 ? Val_Rm << shiftAmt :
               Shift_operand[6:5] == 2'b01 ? Val_Rm >> shiftAmt :
               Shift_operand[6:5] == 2'b10 ? 32'($signed(Val_Rm) >>> shiftAmt) :
                                             32'({Val_Rm, Val_Rm} >> shiftAmt);
    val2     = (MEM_R_EN || MEM_W_EN) ? {20'b0, Shift_operand} : Imm ? rotImm : shifted;
    isSub    = EXE_CMD == 4'b0100 || EXE_CMD == 4'b0101;
    isArith  = isSub || EXE_CMD == 4'b0010 || EXE_CMD == 4'b0011;
    // Subtraction is Rn + ~Val2 + cin so the carry out doubles as "no borrow".
    opB      = isSub ? ~val2 : val2;
    cin      = EXE_CMD == 4'b0100 ? 1'b1 : (EXE_CMD == 4'b0011 || EXE_CMD == 4'b0101) ? Carry : 1'b0;
    sum      = {1'b0, Val_Rn} + {1'b0, opB} + 33'(cin);
    ALU_Res  = isArith              ? sum[31:0] :
               EXE_CMD == 4'b0001   ? val2 :
               EXE_CMD == 4'b1001   ? ~val2 :
               EXE_CMD == 4'b0110   ? Val_Rn & val2 :
               EXE_CMD == 4'b0111   ? Val_Rn | val2 :
               EXE_CMD == 4'b1000   ? Val_Rn ^ val2 : 32'b0;
    nextC    = isArith ? sum[32] : Status[1];
    nextV    = isArith ? (Val_Rn[31] == opB[31]) && (sum[31] != Val_Rn[31]) : Status[0];
  end
  assign Br_Addr       = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  assign Branch_taken  = B;
  assign Val_Rm_out    = Val_Rm;
  assign Dest_out      = Dest;
  assign MEM_R_EN_out  = MEM_R_EN;
  assign MEM_W_EN_out  = MEM_W_EN;
  assign MEM_WB_EN_out = MEM_WB_EN;
  always_ff @(posedge clk or posedge rst)
    if (rst) Status <= 4'b0000;
    else if (S) Status <= {ALU_Res[31], ALU_Res == 32'b0, nextC, nextV};
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vector table, corner sequences and randomized checks against an arithmetic model.
module tb_exe_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  EXE_CMD = '0, Dest = '0;
  logic        MEM_R_EN = 0, MEM_W_EN = 0, MEM_WB_EN = 0, B = 0, S = 0, Imm = 0, Carry = 0;
  logic [31:0] PC = '0, Val_Rn = '0, Val_Rm = '0;
  logic [11:0] Shift_operand = '0;
  logic [23:0] Signed_imm_24 = '0;
  logic [31:0] ALU_Res, Br_Addr, Val_Rm_out;
  logic        Branch_taken, MEM_R_EN_out, MEM_W_EN_out, MEM_WB_EN_out;
  logic [3:0]  Dest_out, Status;
  int passed = 0, total = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .MEM_WB_EN(MEM_WB_EN), .B(B), .S(S), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Imm(Imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest), .Carry(Carry),
    .ALU_Res(ALU_Res), .Br_Addr(Br_Addr), .Branch_taken(Branch_taken), .Val_Rm_out(Val_Rm_out),
    .Dest_out(Dest_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .MEM_WB_EN_out(MEM_WB_EN_out), .Status(Status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [31:0] r = x;
    for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] mVal2(input logic mr, input logic mw, input logic im,
                                        input logic [31:0] rm, input logic [11:0] so);
    int n = int'(so[11:7]);
    if (mr || mw) return {20'b0, so};
    if (im) return rotr({24'b0, so[7:0]}, 2 * int'(so[11:8]));
    case (so[6:5])
      2'd0: return rm << n;
      2'd1: return rm >> n;
      2'd2: return 32'(longint'($signed(rm)) >>> n);
      default: return rotr(rm, n);
    endcase
  endfunction

  task automatic model(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                       input logic cin, input logic [3:0] st,
                       output logic [31:0] res, output logic [3:0] nst);
    longint u, sg, a, b, sa, sb;
    logic c, v;
    a = longint'(rn); b = longint'(v2);
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    c = st[1]; v = st[0]; u = 0; sg = 0;
    case (cmd)
      4'd2: begin u = a + b; sg = sa + sb; end
      4'd3: begin u = a + b + longint'(cin); sg = sa + sb + longint'(cin); end
      4'd4: begin u = a - b; sg = sa - sb; end
      4'd5: begin u = a - b - longint'(!cin); sg = sa - sb - longint'(!cin); end
      default: ;
    endcase
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2, 4'd3, 4'd4, 4'd5: begin
        res = u[31:0];
        c = (cmd <= 4'd3) ? (u >= 64'sh1_0000_0000) : (u >= 0);
        v = sg > 64'sd2147483647 || sg < -64'sd2147483648;
      end
      default: res = '0;
    endcase
    nst = {res[31], res == 32'b0, c, v};
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic        mr, mw, im, s, cin;
    logic [31:0] rn, rm;
    logic [11:0] so;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;
  vec_t vecs[16];

  initial begin
    logic [31:0] eRes, eV2;
    logic [3:0]  eSt, mStat;
    vecs[0]  = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h1,        12'h000, 32'h80000000, 4'b1001};
    vecs[1]  = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5,        32'h0,        12'h005, 32'h0,        4'b0110};
    vecs[2]  = '{4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        12'h4FF, 32'hFF000000, 4'b0110};
    vecs[3]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h80000000, 12'h240, 32'hF8000000, 4'b0110};
    vecs[4]  = '{4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF0000, 32'h80000000, 12'h000, 32'h80000000, 4'b1010};
    vecs[5]  = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        12'h000, 32'h0,        4'b1010};
    vecs[6]  = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h000, 32'h0,        4'b0110};
    vecs[7]  = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,        32'h2,        12'h000, 32'h4,        4'b0000};
    vecs[8]  = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5,        32'h5,        12'h000, 32'hFFFFFFFF, 4'b1000};
    vecs[9]  = '{4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        12'h000, 32'hFFFFFFFF, 4'b1000};
    vecs[10] = '{4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000, 32'h1,        12'h000, 32'h7FFFFFFF, 4'b0011};
    vecs[11] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h9,        12'h000, 32'h0,        4'b0111};
    vecs[12] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80000000, 12'hFA0, 32'h1,        4'b0011};
    vecs[13] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hAB,       12'h460, 32'hAB000000, 4'b0011};
    vecs[14] = '{4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000,     32'h0,        12'hFFF, 32'h1FFF,     4'b0011};
    vecs[15] = '{4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20,       32'h0,        12'h804, 32'h824,      4'b0011};

    // Reset held with an ADDS in flight: no flag update, combinational path still live.
    S = 1; EXE_CMD = 4'h2; Val_Rn = 32'h1; Val_Rm = 32'h1;
    repeat (3) @(posedge clk);
    #1 chk("reset_status", 32'(Status), 32'h0);
    chk("reset_alu_live", ALU_Res, 32'h2);
    @(negedge clk) rst = 0; S = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      EXE_CMD = vecs[i].cmd; MEM_R_EN = vecs[i].mr; MEM_W_EN = vecs[i].mw; Imm = vecs[i].im;
      S = vecs[i].s; Carry = vecs[i].cin; Val_Rn = vecs[i].rn; Val_Rm = vecs[i].rm;
      Shift_operand = vecs[i].so;
      #1 chk($sformatf("vec%0d_res", i), ALU_Res, vecs[i].res);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_status", i), 32'(Status), 32'(vecs[i].st));
    end

    // Branch: target, taken flag, and flags untouched.
    @(negedge clk);
    MEM_R_EN = 0; MEM_W_EN = 0; S = 0; B = 1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
    #1 chk("br_addr", Br_Addr, 32'hF8);
    chk("br_taken", 32'(Branch_taken), 32'h1);
    @(posedge clk);
    #1 chk("br_status_hold", 32'(Status), 32'b0011);

    // Asynchronous reset mid-cycle discards a pending SUBS, then the first edge after release updates.
    @(negedge clk);
    B = 0; S = 1; EXE_CMD = 4'h4; Imm = 0; Val_Rn = 32'h0; Val_Rm = 32'h1; Shift_operand = 12'h0;
    #2 rst = 1;
    #1 chk("async_reset", 32'(Status), 32'h0);
    @(posedge clk);
    #1 chk("reset_no_update", 32'(Status), 32'h0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1 chk("post_reset_update", 32'(Status), 32'b1000);
    mStat = 4'b1000;

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      EXE_CMD = 4'($urandom); MEM_R_EN = ($urandom_range(0, 3) == 0);
      MEM_W_EN = !MEM_R_EN && ($urandom_range(0, 3) == 0); MEM_WB_EN = 1'($urandom);
      B = 1'($urandom); S = 1'($urandom); Imm = 1'($urandom); Carry = 1'($urandom);
      PC = $urandom; Val_Rn = $urandom; Val_Rm = $urandom; Dest = 4'($urandom);
      Shift_operand = 12'($urandom); Signed_imm_24 = 24'($urandom);
      if ($urandom_range(0, 7) == 0) Val_Rm = Val_Rn;
      eV2 = mVal2(MEM_R_EN, MEM_W_EN, Imm, Val_Rm, Shift_operand);
      model(EXE_CMD, Val_Rn, eV2, Carry, mStat, eRes, eSt);
      #1 chk("rnd_res", ALU_Res, eRes);
      chk("rnd_br", Br_Addr, 32'(longint'(PC) + longint'($signed(Signed_imm_24)) * 4));
      chk("rnd_pass", {Val_Rm_out[27:0], Dest_out}, {Val_Rm[27:0], Dest});
      chk("rnd_ctl", {28'b0, Branch_taken, MEM_R_EN_out, MEM_W_EN_out, MEM_WB_EN_out},
          {28'b0, B, MEM_R_EN, MEM_W_EN, MEM_WB_EN});
      @(posedge clk);
      if (S) mStat = eSt;
      #1 chk("rnd_status", 32'(Status), 32'(mStat));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM-subset pipeline. Consumes the ID/EX pipeline register outputs, forms the second operand (Val2), runs the ALU, computes the branch target, and owns the architectural NZCV status register. Its results feed the EX/MEM pipeline register. The status value is returned to the ID stage for condition evaluation.

## Interface
Parameters:
- none. The datapath width is fixed at 32 bits.

Ports:
- `clk`  in  1  Single clock; all state is updated on its rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `EXE_CMD`  in  4  ALU operation select.
- `MEM_R_EN`, `MEM_W_EN`, `MEM_WB_EN`  in  1 each  Memory and writeback controls.
- `B`  in  1  Branch instruction.
- `S`  in  1  Update-status request.
- `PC`  in  32  PC forwarded by ID/EX.
- `Val_Rn`, `Val_Rm`  in  32 each  Register operands.
- `Imm`  in  1  Immediate-operand select.
- `Shift_operand`  in  12  Shift/rotate operand field.
- `Signed_imm_24`  in  24  Branch offset.
- `Dest`  in  4  Destination register.
- `Carry`  in  1  C flag captured at decode; used as the ALU carry-in.
- `ALU_Res`  out  32  ALU result, or the memory address for LDR/STR.
- `Br_Addr`  out  32  Branch target.
- `Branch_taken`  out  1  Equals `B`.
- `Val_Rm_out`  out  32  STR data, passed through unchanged.
- `Dest_out`, `MEM_R_EN_out`, `MEM_W_EN_out`, `MEM_WB_EN_out`  out  Pass-through signals.
- `Status`  out  4  Registered NZCV, with bit order {N,Z,C,V}.

## Operation
- **Val2 selection:**
  - If `MEM_R_EN` or `MEM_W_EN` is high: Val2 = {20'b0, `Shift_operand`}.
  - Else if `Imm` is high: Val2 = {24'b0, `Shift_operand[7:0]`} rotated right by 2×`Shift_operand[11:8]`.
  - Else: Val2 = `Val_Rm` shifted by `Shift_operand[11:7]`, with the shift type given by `Shift_operand[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes `Val_Rm` unchanged.
- **ALU operations (`EXE_CMD`):**
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: Rn+Val2.
  - 0011 ADC: Rn+Val2+`Carry`.
  - 0100 SUB/CMP: Rn−Val2.
  - 0101 SBC: Rn−Val2−!`Carry`.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, with C and V unchanged.
- **Arithmetic width:** arithmetic is done at 33 bits. C is bit 32 of the sum. For subtraction, C is the carry of Rn + ~Val2 + cin, so C=1 means no borrow. V=1 when the operands' signs give a result sign overflow (add: operands same sign and result sign differs; sub: operands differ in sign and result sign differs from Rn).
- **Logic and move ops:** the next C and V equal the current `Status` C and V.
- **N and Z:** N is result bit 31. Z is 1 exactly when the result equals 0.
- **Branch target:** `Br_Addr` = `PC` + (sign-extended `Signed_imm_24` << 2), computed modulo 2^32.
- **Status register:** at a rising edge of `clk`, when `S`=1, `Status` loads {N,Z,C,V}. When `S`=0, `Status` holds. Branches and memory ops arrive with S=0 from decode, and this block does not override `S`.
- All outputs other than `Status` are combinational from the inputs.

## Timing
- `rst` high clears `Status` to 4'b0000 immediately, without waiting for a clock edge. Combinational outputs follow their inputs during reset.
- Latency: the combinational outputs are valid within the same cycle that the ID/EX register presents the instruction.
- `Status` changes one edge later. The instruction in ID during the following cycle sees the new flags.
- An instruction with `S`=1 squashed by the upstream flush arrives as all-zero controls. All-zero controls mean S=0, so no flag update occurs.
- Reset asserted mid-instruction discards any pending flag update. The first edge after `rst` deasserts may update `Status` normally.

## Test plan
- Reset: drive `rst`=1 with `S`=1 and an ADD in flight → `Status`=0000, with no update while reset is held.
- ADDS overflow: Rn=0x7FFFFFFF, register operand Rm=1 with LSL 0, S=1 → `ALU_Res`=0x80000000, and after the edge `Status`=1001.
- SUBS equal: Rn=5, Imm=1, imm8=5, rot=0, S=1 → `ALU_Res`=0, and `Status`=0110 (Z=1, C=1 meaning no borrow).
- Immediate rotate: imm8=0xFF, rot=4 (rotate right 8), MOV → `ALU_Res`=0xFF000000. Then ASR by 4 of Rm=0x80000000 → 0xF8000000.
- Branch: PC=0x100, Signed_imm_24=0xFFFFFE (−2), B=1 → `Br_Addr`=0xF8, `Branch_taken`=1, and `Status` unchanged.
- S=0 hold: load `Status`=0110, then issue ANDS followed by ORR with S=0 → ANDS sets N and Z and keeps C=1, V=0. The ORR leaves `Status` unchanged.
